// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types for the 5-stage MIPS core: the ID/EX control bundle and next-PC encodings.
package cpu_pipe_pkg;

  localparam int unsigned CTRL_W = 20;
  localparam int unsigned RA_IDX = 31;

  typedef enum logic [1:0] {
    NpcPc4 = 2'b00,
    NpcBr  = 2'b01,
    NpcJ   = 2'b10,
    NpcJr  = 2'b11
  } npc_op_e;

  // Field order matches the ID decoder output, MSB first.
  typedef struct packed {
    logic       reg_dst;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_write;
    logic       alu_src;
    npc_op_e    npc_op;
    logic [3:0] alu_op;
    logic       shift_index;
    logic       shift_dir;
    logic       alu_a_src;
    logic       call;
    logic [3:0] rsv;
  } ctrl_t;

endpackage

// File: rtl/id_ex_hazard.sv
// Load-use comparator: an EX-stage load whose destination is read by the ID instruction.
module id_ex_hazard #(
  parameter int unsigned RW = 5
) (
  input  logic          ex_valid,
  input  logic          ex_mem_read,
  input  logic [RW-1:0] ex_dst,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  output logic          load_use_stall
);

  // rt is compared even for instructions that do not read it; a spare bubble is harmless.
  assign load_use_stall = ex_valid & ex_mem_read & id_valid & (ex_dst != '0) &
                          ((ex_dst == id_rs) | (ex_dst == id_rt));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and destination resolution.
// Optional IDEX_BUBBLE_CNT_EN adds a saturating bubble counter output.
module id_ex_stage_reg #(
  parameter int unsigned DW     = 32,
  parameter int unsigned RW     = 5,
  parameter int unsigned RA_IDX = cpu_pipe_pkg::RA_IDX
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            id_valid,
  input  logic [cpu_pipe_pkg::CTRL_W-1:0] id_ctrl,
  input  logic [DW-1:0]                   id_pc4,
  input  logic [DW-1:0]                   id_rs_data,
  input  logic [DW-1:0]                   id_rt_data,
  input  logic [DW-1:0]                   id_imm,
  input  logic [RW-1:0]                   id_rs,
  input  logic [RW-1:0]                   id_rt,
  input  logic [RW-1:0]                   id_rd,
  input  logic [4:0]                      id_shamt,
  input  logic                            stall_in,
  input  logic                            flush_in,
  output logic                            load_use_stall,
  output logic                            ex_valid,
  output logic [cpu_pipe_pkg::CTRL_W-1:0] ex_ctrl,
  output logic [DW-1:0]                   ex_pc4,
  output logic [DW-1:0]                   ex_rs_data,
  output logic [DW-1:0]                   ex_rt_data,
  output logic [DW-1:0]                   ex_imm,
  output logic [RW-1:0]                   ex_rs,
  output logic [RW-1:0]                   ex_rt,
  output logic [4:0]                      ex_shamt,
`ifdef IDEX_BUBBLE_CNT_EN
  output logic [31:0]                     bubble_cnt,
`endif
  output logic [RW-1:0]                   ex_dst
);

  import cpu_pipe_pkg::*;

  ctrl_t         id_ctrl_s;
  ctrl_t         ex_ctrl_q;
  logic          ex_valid_q;
  logic [DW-1:0] ex_pc4_q, ex_rs_data_q, ex_rt_data_q, ex_imm_q;
  logic [RW-1:0] ex_rs_q, ex_rt_q, ex_dst_q, id_dst;
  logic [4:0]    ex_shamt_q;
  logic          bubble;

  assign id_ctrl_s = ctrl_t'(id_ctrl);

  always_comb begin
    id_dst = id_rt;
    if (id_ctrl_s.call) begin
      id_dst = RW'(RA_IDX);
    end else if (id_ctrl_s.reg_dst) begin
      id_dst = id_rd;
    end
  end

  id_ex_hazard #(
    .RW(RW)
  ) u_hazard (
    .ex_valid       (ex_valid_q),
    .ex_mem_read    (ex_ctrl_q.mem_read),
    .ex_dst         (ex_dst_q),
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .load_use_stall (load_use_stall)
  );

  assign bubble = flush_in | load_use_stall;

  // A downstream stall freezes EX outright; a flushing branch may be the instruction held there.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_pc4_q     <= '0;
      ex_rs_data_q <= '0;
      ex_rt_data_q <= '0;
      ex_imm_q     <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_shamt_q   <= '0;
      ex_dst_q     <= '0;
    end else if (!stall_in) begin
      ex_valid_q   <= id_valid & ~bubble;
      ex_ctrl_q    <= (id_valid & ~bubble) ? id_ctrl_s : '0;
      ex_pc4_q     <= id_pc4;
      ex_rs_data_q <= id_rs_data;
      ex_rt_data_q <= id_rt_data;
      ex_imm_q     <= id_imm;
      ex_rs_q      <= id_rs;
      ex_rt_q      <= id_rt;
      ex_shamt_q   <= id_shamt;
      ex_dst_q     <= id_dst;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_pc4     = ex_pc4_q;
  assign ex_rs_data = ex_rs_data_q;
  assign ex_rt_data = ex_rt_data_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_shamt   = ex_shamt_q;
  assign ex_dst     = ex_dst_q;

`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (!stall_in && bubble && bubble_cnt_q != '1) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: directed vector table followed by randomized traffic vs a reference model.
module tb_id_ex_stage_reg;

  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [19:0] C_ADD = 20'h88100;
  localparam logic [19:0] C_LW  = 20'h6C100;
  localparam logic [19:0] C_JAL = 20'h0A010;
  localparam logic [19:0] C_SW  = 20'h14100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, id_valid, stall_in, flush_in;
  logic [19:0]   id_ctrl;
  logic [DW-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic [4:0]    id_shamt;
  logic          load_use_stall, ex_valid;
  logic [19:0]   ex_ctrl;
  logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [RW-1:0] ex_rs, ex_rt, ex_dst;
  logic [4:0]    ex_shamt;
`ifdef IDEX_BUBBLE_CNT_EN
  logic [31:0]   bubble_cnt;
`endif

  id_ex_stage_reg dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_ctrl        (id_ctrl),
    .id_pc4         (id_pc4),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm         (id_imm),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .id_shamt       (id_shamt),
    .stall_in       (stall_in),
    .flush_in       (flush_in),
    .load_use_stall (load_use_stall),
    .ex_valid       (ex_valid),
    .ex_ctrl        (ex_ctrl),
    .ex_pc4         (ex_pc4),
    .ex_rs_data     (ex_rs_data),
    .ex_rt_data     (ex_rt_data),
    .ex_imm         (ex_imm),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_shamt       (ex_shamt),
`ifdef IDEX_BUBBLE_CNT_EN
    .bubble_cnt     (bubble_cnt),
`endif
    .ex_dst         (ex_dst)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, stall, flush, vld;
    logic [19:0] ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] pc4;
    logic        chk_lus, exp_lus, exp_vld;
    logic [19:0] exp_ctrl;
    logic        chk_data;
    logic [4:0]  exp_dst;
    logic [31:0] exp_pc4;
    int          bub_inc;
  } vec_t;

  function automatic vec_t mk(input logic r, s, f, v, input logic [19:0] c,
                              input logic [4:0] rs, rt, rd, input logic [31:0] pc4,
                              input logic cl, el, ev, input logic [19:0] ec,
                              input logic cd, input logic [4:0] ed, input logic [31:0] ep,
                              input int bi);
    vec_t t;
    t.rst = r; t.stall = s; t.flush = f; t.vld = v; t.ctrl = c;
    t.rs = rs; t.rt = rt; t.rd = rd; t.pc4 = pc4;
    t.chk_lus = cl; t.exp_lus = el; t.exp_vld = ev; t.exp_ctrl = ec;
    t.chk_data = cd; t.exp_dst = ed; t.exp_pc4 = ep; t.bub_inc = bi;
    return t;
  endfunction

  // Reference model of the EX slot, kept at the level of the stated rules.
  typedef struct {
    logic        valid;
    logic [19:0] ctrl;
    logic        known;
    logic [31:0] pc4, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, shamt, dst;
  } ex_model_t;

  function automatic logic [4:0] dest_of(input logic [19:0] c, input logic [4:0] rt,
                                         input logic [4:0] rd);
    if (c[4]) return 5'd31;
    if (c[19]) return rd;
    return rt;
  endfunction

  function automatic logic hazard_of(input ex_model_t m, input logic vld, input logic [4:0] rs,
                                     input logic [4:0] rt);
    return m.valid && m.ctrl[18] && vld && m.dst != 0 && (m.dst == rs || m.dst == rt);
  endfunction

  vec_t      vecs[13];
  ex_model_t m;
  longint    bub_exp;
  logic      exp_l;

  initial begin
    rst = 1'b1; id_valid = 0; stall_in = 0; flush_in = 0; id_ctrl = '0;
    id_pc4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_shamt = '0;
    bub_exp = 0;

    //            rst s f v ctrl   rs rt rd pc4           cl el ev ectrl  cd dst pc4     bub
    vecs[0]  = mk(1, 0, 0, 1, C_ADD, 1, 2, 3, 32'h400000, 0, 0, 0, 20'h0, 1, 0, 32'h0, 0);
    vecs[1]  = mk(0, 0, 0, 1, C_ADD, 1, 2, 3, 32'h400004, 1, 0, 1, C_ADD, 1, 3, 32'h400004, 0);
    vecs[2]  = mk(0, 0, 0, 1, C_JAL, 0, 0, 0, 32'h400008, 1, 0, 1, C_JAL, 1, 31, 32'h400008, 0);
    vecs[3]  = mk(0, 0, 0, 1, C_LW,  1, 5, 0, 32'h40000c, 1, 0, 1, C_LW,  1, 5, 32'h40000c, 0);
    vecs[4]  = mk(0, 0, 0, 1, C_ADD, 5, 1, 6, 32'h400010, 1, 1, 0, 20'h0, 0, 0, 32'h0, 1);
    vecs[5]  = mk(0, 0, 0, 1, C_ADD, 5, 1, 6, 32'h400010, 1, 0, 1, C_ADD, 1, 6, 32'h400010, 0);
    vecs[6]  = mk(0, 0, 1, 1, C_SW,  2, 6, 0, 32'h400014, 1, 0, 0, 20'h0, 0, 0, 32'h0, 1);
    vecs[7]  = mk(0, 0, 0, 1, C_LW,  1, 7, 0, 32'h400018, 1, 0, 1, C_LW,  1, 7, 32'h400018, 0);
    vecs[8]  = mk(0, 1, 1, 1, C_ADD, 7, 2, 8, 32'h40001c, 1, 1, 1, C_LW,  1, 7, 32'h400018, 0);
    vecs[9]  = mk(1, 1, 1, 1, C_ADD, 7, 2, 8, 32'h40001c, 1, 1, 0, 20'h0, 1, 0, 32'h0, 0);
    vecs[10] = mk(0, 0, 0, 1, C_LW,  1, 0, 0, 32'h400020, 1, 0, 1, C_LW,  1, 0, 32'h400020, 0);
    vecs[11] = mk(0, 0, 0, 1, C_ADD, 0, 0, 4, 32'h400024, 1, 0, 1, C_ADD, 1, 4, 32'h400024, 0);
    vecs[12] = mk(0, 0, 0, 0, C_ADD, 4, 4, 4, 32'h400028, 1, 0, 0, 20'h0, 0, 0, 32'h0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; stall_in = vecs[i].stall; flush_in = vecs[i].flush;
      id_valid = vecs[i].vld; id_ctrl = vecs[i].ctrl; id_rs = vecs[i].rs;
      id_rt = vecs[i].rt; id_rd = vecs[i].rd; id_pc4 = vecs[i].pc4;
      id_rs_data = vecs[i].pc4 ^ 32'h1111; id_rt_data = vecs[i].pc4 ^ 32'h2222;
      id_imm = vecs[i].pc4 ^ 32'h3333; id_shamt = 5'(i + 1);
      #1;
      if (vecs[i].chk_lus) check($sformatf("v%0d_lus", i), 64'(load_use_stall),
                                 64'(vecs[i].exp_lus));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), 64'(ex_valid), 64'(vecs[i].exp_vld));
      check($sformatf("v%0d_ctrl", i), 64'(ex_ctrl), 64'(vecs[i].exp_ctrl));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_dst", i), 64'(ex_dst), 64'(vecs[i].exp_dst));
        check($sformatf("v%0d_pc4", i), 64'(ex_pc4), 64'(vecs[i].exp_pc4));
      end
      if (vecs[i].rst) begin
        check($sformatf("v%0d_rst_data", i),
              {ex_rs_data, ex_rt_data} | {32'h0, ex_imm} | {49'h0, ex_rs, ex_rt, ex_shamt}, 64'h0);
        check($sformatf("v%0d_rst_lus", i), 64'(load_use_stall), 64'h0);
        bub_exp = 0;
      end else begin
        bub_exp += vecs[i].bub_inc;
      end
`ifdef IDEX_BUBBLE_CNT_EN
      check($sformatf("v%0d_bubble_cnt", i), 64'(bubble_cnt), 64'(bub_exp));
`endif
    end

    // Randomized traffic; small register indices keep hazards frequent.
    m = '{default: '0};
    m.known = 1'b1;
    @(negedge clk);
    rst = 1'b1; stall_in = 0; flush_in = 0;
    @(posedge clk);
    bub_exp = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 49) == 0);
      stall_in = ($urandom_range(0, 4) == 0);
      flush_in = ($urandom_range(0, 6) == 0);
      id_valid = ($urandom_range(0, 5) != 0);
      id_ctrl = 20'($urandom) & 20'hFFFF0;
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3)); id_shamt = 5'($urandom);
      id_pc4 = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      #1;
      exp_l = hazard_of(m, id_valid, id_rs, id_rt);
      check("rnd_lus", 64'(load_use_stall), 64'(exp_l));
      @(posedge clk);
      #1;
      if (rst) begin
        m = '{default: '0};
        m.known = 1'b1;
        bub_exp = 0;
      end else if (!stall_in) begin
        if (flush_in || exp_l) begin
          m.valid = 0; m.ctrl = '0; m.known = 0;
          if (bub_exp < 64'hFFFFFFFF) bub_exp++;
        end else begin
          m.valid = id_valid; m.ctrl = id_valid ? id_ctrl : 20'h0; m.known = 1;
          m.pc4 = id_pc4; m.rs_data = id_rs_data; m.rt_data = id_rt_data; m.imm = id_imm;
          m.rs = id_rs; m.rt = id_rt; m.shamt = id_shamt;
          m.dst = dest_of(id_ctrl, id_rt, id_rd);
        end
      end
      check("rnd_valid", 64'(ex_valid), 64'(m.valid));
      check("rnd_ctrl", 64'(ex_ctrl), 64'(m.ctrl));
      if (m.known) begin
        check("rnd_dst", 64'(ex_dst), 64'(m.dst));
        check("rnd_pc4", 64'(ex_pc4), 64'(m.pc4));
        check("rnd_data", {ex_rs_data, ex_rt_data}, {m.rs_data, m.rt_data});
        check("rnd_imm", 64'(ex_imm), 64'(m.imm));
        check("rnd_idx", 64'({ex_rs, ex_rt, ex_shamt}), 64'({m.rs, m.rt, m.shamt}));
      end
`ifdef IDEX_BUBBLE_CNT_EN
      check("rnd_bubble_cnt", 64'(bubble_cnt), 64'(bub_exp));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register for the 5-stage MIPS core; sits directly downstream of the ID-stage control decoder.
- Latches the decoder's control bundle together with the ID operands, and resolves the write-back destination register.
- Detects load-use hazards and inserts bubbles on load-use or branch/jump flush.
- Produces the stall request that freezes PC and IF/ID.

Parameters:
- DW, 32, datapath width (PC+4, register data, extended immediate).
- RW, 5, register index width.
- RA_IDX, 31, destination index forced for call (jal/jalr).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  20  {RegDst,MemRead,MemtoReg,MemWrite,RegWrite,ALUSrc,NPCOP[1:0],ALUOp[3:0],ShiftIndex,ShiftDirection,ALUasrc,call,rsv[3:0]=0}
- id_pc4  in  DW  PC+4 of ID instruction
- id_rs_data, id_rt_data  in  DW  register file read data
- id_imm  in  DW  extended immediate (EXTOP already applied in ID)
- id_rs, id_rt, id_rd  in  RW  instruction fields [25:21],[20:16],[15:11]
- id_shamt  in  5  Ins[10:6]
- stall_in  in  1  downstream (MEM) stall; hold register
- flush_in  in  1  taken branch/jump resolved in EX; kill entering instruction
- load_use_stall  out  1  combinational; freeze PC and IF/ID
- ex_valid  out  1  EX holds a real instruction
- ex_ctrl  out  20  registered control bundle
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DW  registered operands
- ex_rs, ex_rt  out  RW  registered indices (for forwarding)
- ex_shamt  out  5  registered shamt
- ex_dst  out  RW  registered destination: RA_IDX if call, else id_rd if RegDst, else id_rt

Behaviour:
- Reset: every output register is 0 (ex_valid=0, ex_ctrl=0, ex_dst=0). load_use_stall is 0 while ex_valid=0.
- Latency: one cycle; the ID value presented at edge N appears at ex_* after edge N.
- load_use_stall = ex_valid & ex_ctrl.MemRead & id_valid & (ex_dst!=0) & (ex_dst==id_rs | ex_dst==id_rt). The compare is deliberately conservative, because rt is not used by every instruction.
- Next-state priority per edge:
  1. rst: clear all.
  2. stall_in: hold every register unchanged; flush_in and the hazard are ignored this edge (the instruction in EX may itself be the flushing branch).
  3. flush_in or load_use_stall: load a bubble. ex_valid=0 and ex_ctrl=0, so RegWrite, MemWrite and MemRead are all 0 and NPCOP=00. Data fields may load ID values (don't-care).
  4. Otherwise: capture ID. ex_valid=id_valid; ex_ctrl=id_valid?id_ctrl:0.
- A bubble never asserts RegWrite, MemWrite or MemRead.
- Back-to-back load-use: at most one bubble per hazard. After the bubble, ex_valid=0 clears load_use_stall and the held ID instruction enters.
- Register 0 is never the source of a hazard.
- Reset mid-stall: the reset wins the same edge; no state is retained.

Optional Feature:
- Macro IDEX_BUBBLE_CNT_EN.
- When defined: adds output bubble_cnt (32 bits), a counter that increments on every edge where a bubble is loaded and stall_in=0. It clears on rst and saturates at 0xFFFFFFFF.
- When undefined: the port and counter do not exist. All other behaviour is identical.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - the control-bundle typedef, with the field order given above;
  - its width constant CTRL_W=20;
  - RA_IDX;
  - the NPCOP encodings PC4=00, BR=01, J=10, JR=11.
- One sub-module, id_ex_hazard: combinational load-use comparator producing load_use_stall. It is reused by a later forwarding unit.

Test Plan:
- Normal capture: add $3,$1,$2 (RegDst=1, RegWrite=1, ALUOp=0001, id_rd=3), id_valid=1 -> next cycle ex_valid=1, ex_dst=3, ex_ctrl matches the input.
- Call destination: jal (call=1, NPCOP=10, RegWrite=1) -> ex_dst=31, ex_pc4 equals id_pc4 (e.g. 0x00400008).
- Load-use: lw $5 in EX, add $6,$5,$1 in ID -> load_use_stall=1 for exactly one cycle. A bubble follows (ex_valid=0, RegWrite=0), then add enters with ex_dst=6.
- Flush: flush_in=1 with sw in ID -> next ex_valid=0, MemWrite=0. With IDEX_BUBBLE_CNT_EN, bubble_cnt increments by 1.
- Stall priority: stall_in=1 with flush_in=1 and a load-use match -> all ex_* are unchanged that edge and bubble_cnt is unchanged.
- Reset: rst=1 while stalled with ex_valid=1 -> after the edge every output is 0 and load_use_stall=0. A $0 destination load followed by a user of $0 -> no stall.
